// File: rtl/spi_arb.sv
`timescale 1ns/1ps
// spi_arb: round-robin arbiter sharing one SPI master among three requesters.
// Latency: req sampled at edge k -> gnt/spi_wrt in cycle k+1; spi_done in cycle d -> ack in d+1.
// Backpressure: one transaction in flight; req held until ack, ignored during BUSY and GAP.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   req_i[2:0]        per-requester request, held until that requester's ack
//   req_cmd_i[47:0]   requester i command in bits [16i+15:16i]
//   gnt_o[2:0]        one-hot grant, issue through completion
//   ack_o[2:0]        one-cycle completion pulse to the granted requester
//   err_o             one-cycle pulse with ack when the transaction timed out
//   resp_data_o       read data, valid with ack, held until the next ack
//   spi_wrt_o         one-cycle start strobe to the SPI master
//   spi_cmd_o         latched command, held until the next issue
//   spi_done_i        master completion pulse (only honoured in BUSY)
//   spi_rd_data_i     master read data, sampled with spi_done_i
module spi_arb #(
    parameter int GAP_CYC = 4,
    parameter int TIMEOUT = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_i,
    input  logic [47:0] req_cmd_i,
    output logic [2:0]  gnt_o,
    output logic [2:0]  ack_o,
    output logic        err_o,
    output logic [15:0] resp_data_o,
    output logic        spi_wrt_o,
    output logic [15:0] spi_cmd_o,
    input  logic        spi_done_i,
    input  logic [15:0] spi_rd_data_i
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam int GP_W = $clog2(GAP_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    // With GAP_CYC=0 the GAP state is never entered, so this value goes unused.
    localparam logic [GP_W-1:0] GP_LAST = GP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q;
    logic [1:0]      ptr_q;
    logic [1:0]      own_q;
    logic [WD_W-1:0] wdog_q;
    logic [WD_W-1:0] wdog_d;
    logic [GP_W-1:0] gap_q;
    logic [GP_W-1:0] gap_d;
    logic [2:0]      gnt_q;
    logic [2:0]      ack_q;
    logic            err_q;
    logic [15:0]     resp_data_q;
    logic            spi_wrt_q;
    logic [15:0]     spi_cmd_q;

    logic            win_vld;
    logic [1:0]      win_idx;
    logic            finish;

    // Round-robin search starting at ptr_q: first requester with req high wins.
    always_comb begin
        int         cand_int;
        logic [1:0] cand;
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int k = 0; k < 3; k++) begin
            cand_int = int'(ptr_q) + k;
            if (cand_int >= 3) begin
                cand_int = cand_int - 3;
            end
            cand = 2'(cand_int);
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Saturating counters: they stop at all-ones instead of wrapping.
    always_comb begin
        wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + WD_W'(1);
        gap_d  = (gap_q == '1) ? gap_q : gap_q + GP_W'(1);
    end

    // Done takes precedence over the watchdog when both hit in the same cycle.
    assign finish = spi_done_i || (wdog_q == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= 2'd0;
            own_q       <= 2'd0;
            wdog_q      <= '0;
            gap_q       <= '0;
            gnt_q       <= 3'b000;
            ack_q       <= 3'b000;
            err_q       <= 1'b0;
            resp_data_q <= 16'h0000;
            spi_wrt_q   <= 1'b0;
            spi_cmd_q   <= 16'h0000;
        end else begin
            spi_wrt_q <= 1'b0;
            ack_q     <= 3'b000;
            err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        own_q     <= win_idx;
                        gnt_q     <= 3'b001 << win_idx;
                        spi_cmd_q <= req_cmd_i[16*win_idx +: 16];
                        spi_wrt_q <= 1'b1;
                        wdog_q    <= '0;
                        state_q   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    wdog_q <= wdog_d;
                    if (finish) begin
                        resp_data_q <= spi_done_i ? spi_rd_data_i : 16'h0000;
                        err_q       <= !spi_done_i;
                        ack_q       <= gnt_q;
                        gnt_q       <= 3'b000;
                        ptr_q       <= (own_q == 2'd2) ? 2'd0 : own_q + 2'd1;
                        gap_q       <= '0;
                        state_q     <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign resp_data_o = resp_data_q;
    assign spi_wrt_o   = spi_wrt_q;
    assign spi_cmd_o   = spi_cmd_q;

endmodule
